// File: rtl/register_file_scoreboard_if.sv
// Bundle of read, writeback and reservation signals for register_file_scoreboard.
// master drives requests; slave (the register file) returns read results and occupancy.
interface register_file_scoreboard_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_COUNT  = 32,
  parameter int unsigned READ_PORTS = 2
);
  localparam int unsigned IW = $clog2(REG_COUNT);

  logic [READ_PORTS-1:0]      read_enable;
  logic [READ_PORTS*IW-1:0]   read_index;
  logic [READ_PORTS*XLEN-1:0] read_data;
  logic [READ_PORTS-1:0]      read_busy;
  logic                       write_enable;
  logic [IW-1:0]              write_index;
  logic [XLEN-1:0]            write_data;
  logic                       reserve_enable;
  logic [IW-1:0]              reserve_index;
  logic [IW:0]                busy_count;

  modport master (
    output read_enable, read_index, write_enable, write_index, write_data,
           reserve_enable, reserve_index,
    input  read_data, read_busy, busy_count
  );

  modport slave (
    input  read_enable, read_index, write_enable, write_index, write_data,
           reserve_enable, reserve_index,
    output read_data, read_busy, busy_count
  );
endinterface

// File: rtl/register_file_scoreboard.sv
// Register file with per-register busy (scoreboard) bits, write-first read bypass
// and a running count of outstanding reservations.
module register_file_scoreboard #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_COUNT  = 32,
  parameter int unsigned READ_PORTS = 2
) (
  input  logic                         CLK,
  input  logic                         reset,
  register_file_scoreboard_if.slave    bus
);
  localparam int unsigned IW = $clog2(REG_COUNT);
  localparam int unsigned CW = IW + 1;

  logic [REG_COUNT-1:0][XLEN-1:0]  regs_q, regs_d;
  logic [REG_COUNT-1:0]            busy_q, busy_d;
  logic [READ_PORTS-1:0][XLEN-1:0] read_data_q, read_data_d;
  logic [READ_PORTS-1:0]           read_busy_q, read_busy_d;
  logic [CW-1:0]                   busy_count_q, busy_count_d;
  logic [READ_PORTS-1:0][IW-1:0]   rd_idx;

  logic wr_hit, rsv_hit, same_idx, cnt_inc, cnt_dec;

  assign rd_idx = bus.read_index;

  // Writeback and reservation; reservation is applied last so it wins a collision.
  always_comb begin
    regs_d       = regs_q;
    busy_d       = busy_q;
    wr_hit       = bus.write_enable && (bus.write_index != '0);
    rsv_hit      = bus.reserve_enable && (bus.reserve_index != '0);
    same_idx     = wr_hit && rsv_hit && (bus.write_index == bus.reserve_index);
    if (wr_hit) begin
      regs_d[bus.write_index] = bus.write_data;
      busy_d[bus.write_index] = 1'b0;
    end
    if (rsv_hit) begin
      busy_d[bus.reserve_index] = 1'b1;
    end
    cnt_inc      = rsv_hit && !busy_q[bus.reserve_index];
    cnt_dec      = wr_hit && busy_q[bus.write_index] && !same_idx;
    busy_count_d = busy_count_q + CW'(cnt_inc) - CW'(cnt_dec);
  end

  // Read ports: x0 is hard zero, a same-cycle write bypasses the array.
  always_comb begin
    read_data_d = read_data_q;
    read_busy_d = read_busy_q;
    for (int k = 0; k < int'(READ_PORTS); k++) begin
      if (bus.read_enable[k]) begin
        if (rd_idx[k] == '0) begin
          read_data_d[k] = '0;
          read_busy_d[k] = 1'b0;
        end else if (wr_hit && (bus.write_index == rd_idx[k])) begin
          read_data_d[k] = bus.write_data;
          read_busy_d[k] = rsv_hit && (bus.reserve_index == rd_idx[k]);
        end else begin
          read_data_d[k] = regs_q[rd_idx[k]];
          read_busy_d[k] = busy_q[rd_idx[k]];
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      regs_q       <= '0;
      busy_q       <= '0;
      read_data_q  <= '0;
      read_busy_q  <= '0;
      busy_count_q <= '0;
    end else begin
      regs_q       <= regs_d;
      busy_q       <= busy_d;
      read_data_q  <= read_data_d;
      read_busy_q  <= read_busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  assign bus.read_data  = read_data_q;
  assign bus.read_busy  = read_busy_q;
  assign bus.busy_count = busy_count_q;

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Directed bench for register_file_scoreboard: default 32x32x2 instance driven from a
// vector table, plus hold/reset sequences and an 8-entry, 3-port, 16-bit instance.
module tb_register_file_scoreboard;
  logic clk;
  logic rst;

  register_file_scoreboard_if #(.XLEN(32), .REG_COUNT(32), .READ_PORTS(2)) bus ();
  register_file_scoreboard_if #(.XLEN(16), .REG_COUNT(8),  .READ_PORTS(3)) bus8 ();

  register_file_scoreboard #(.XLEN(32), .REG_COUNT(32), .READ_PORTS(2)) u_dut (
    .CLK(clk), .reset(rst), .bus(bus)
  );
  register_file_scoreboard #(.XLEN(16), .REG_COUNT(8), .READ_PORTS(3)) u_dut8 (
    .CLK(clk), .reset(rst), .bus(bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  re;
    logic [4:0]  ri0, ri1;
    logic        we;
    logic [4:0]  wi;
    logic [31:0] wd;
    logic        rv;
    logic [4:0]  rvi;
    logic [31:0] ed0, ed1;
    logic [1:0]  eb;
    logic [5:0]  ec;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];
  int checks;
  int failures;

  function automatic vec_t mk(input logic [1:0] re, input logic [4:0] ri0, input logic [4:0] ri1,
                              input logic we, input logic [4:0] wi, input logic [31:0] wd,
                              input logic rv, input logic [4:0] rvi,
                              input logic [31:0] ed0, input logic [31:0] ed1,
                              input logic [1:0] eb, input logic [5:0] ec);
    vec_t v;
    v.re = re; v.ri0 = ri0; v.ri1 = ri1; v.we = we; v.wi = wi; v.wd = wd;
    v.rv = rv; v.rvi = rvi; v.ed0 = ed0; v.ed1 = ed1; v.eb = eb; v.ec = ec;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] re, input logic [4:0] ri0, input logic [4:0] ri1,
                       input logic we, input logic [4:0] wi, input logic [31:0] wd,
                       input logic rv, input logic [4:0] rvi);
    bus.read_enable    = re;
    bus.read_index     = {ri1, ri0};
    bus.write_enable   = we;
    bus.write_index    = wi;
    bus.write_data     = wd;
    bus.reserve_enable = rv;
    bus.reserve_index  = rvi;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string nm, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [1:0] b, input logic [5:0] c);
    chk({nm, " data0"}, 64'(bus.read_data[31:0]), 64'(d0));
    chk({nm, " data1"}, 64'(bus.read_data[63:32]), 64'(d1));
    chk({nm, " busy"}, 64'(bus.read_busy), 64'(b));
    chk({nm, " count"}, 64'(bus.busy_count), 64'(c));
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    vecs[0]  = mk(2'b00, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 32'h0,        32'h0,    2'b00, 0);
    vecs[1]  = mk(2'b01, 5, 0, 0, 0, 32'h0,        0, 0, 32'hDEADBEEF, 32'h0,    2'b00, 0);
    vecs[2]  = mk(2'b10, 0, 7, 1, 7, 32'h1234,     0, 0, 32'hDEADBEEF, 32'h1234, 2'b00, 0);
    vecs[3]  = mk(2'b10, 0, 0, 1, 0, 32'hFFFF,     0, 0, 32'hDEADBEEF, 32'h0,    2'b00, 0);
    vecs[4]  = mk(2'b11, 7, 0, 0, 0, 32'h0,        0, 0, 32'h1234,     32'h0,    2'b00, 0);
    vecs[5]  = mk(2'b00, 0, 0, 0, 0, 32'h0,        1, 3, 32'h1234,     32'h0,    2'b00, 1);
    vecs[6]  = mk(2'b01, 3, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0,    2'b01, 1);
    vecs[7]  = mk(2'b00, 0, 0, 1, 3, 32'h55,       0, 0, 32'h0,        32'h0,    2'b01, 0);
    vecs[8]  = mk(2'b11, 3, 3, 0, 0, 32'h0,        0, 0, 32'h55,       32'h55,   2'b00, 0);
    vecs[9]  = mk(2'b01, 9, 0, 0, 0, 32'h0,        1, 9, 32'h0,        32'h55,   2'b00, 1);
    vecs[10] = mk(2'b10, 0, 9, 1, 9, 32'hAA,       1, 9, 32'h0,        32'hAA,   2'b10, 1);
    vecs[11] = mk(2'b01, 9, 0, 0, 0, 32'h0,        0, 0, 32'hAA,       32'hAA,   2'b11, 1);
    vecs[12] = mk(2'b11, 9, 4, 1, 9, 32'hBB,       1, 4, 32'hBB,       32'h0,    2'b00, 1);
    vecs[13] = mk(2'b10, 0, 4, 0, 0, 32'h0,        0, 0, 32'hBB,       32'h0,    2'b10, 1);
    vecs[14] = mk(2'b00, 0, 0, 1, 4, 32'hCAFE,     0, 0, 32'hBB,       32'h0,    2'b10, 0);
    vecs[15] = mk(2'b01, 6, 0, 1, 6, 32'h11,       0, 0, 32'h11,       32'h0,    2'b10, 0);
    vecs[16] = mk(2'b11, 0, 4, 0, 0, 32'h0,        1, 0, 32'h0,        32'hCAFE, 2'b00, 0);

    rst = 1'b1;
    drive(2'b00, 0, 0, 0, 0, 32'h0, 0, 0);
    bus8.read_enable = '0; bus8.read_index = '0; bus8.write_enable = 1'b0;
    bus8.write_index = '0; bus8.write_data = '0; bus8.reserve_enable = 1'b0;
    bus8.reserve_index = '0;
    step();
    step();
    chk32("reset", 32'h0, 32'h0, 2'b00, 6'd0);
    chk("reset dut8 count", 64'(bus8.busy_count), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].re, vecs[i].ri0, vecs[i].ri1, vecs[i].we, vecs[i].wi, vecs[i].wd,
            vecs[i].rv, vecs[i].rvi);
      step();
      chk32($sformatf("vec%0d", i), vecs[i].ed0, vecs[i].ed1, vecs[i].eb, vecs[i].ec);
    end

    // Hold: read x5 while reserving x2, then idle ports while x5 is rewritten.
    drive(2'b01, 5, 0, 0, 0, 32'h0, 1, 2);
    step();
    chk("hold load data0", 64'(bus.read_data[31:0]), 64'hDEADBEEF);
    chk("hold load count", 64'(bus.busy_count), 64'd1);
    for (int h = 0; h < 3; h++) begin
      drive(2'b00, 0, 0, 1, 5, 32'h77, 0, 0);
      step();
      chk($sformatf("hold%0d data0", h), 64'(bus.read_data[31:0]), 64'hDEADBEEF);
      chk($sformatf("hold%0d busy0", h), 64'(bus.read_busy[0]), 64'd0);
    end

    // Reset between edges with a write and reservation pending.
    drive(2'b01, 5, 0, 1, 5, 32'h99, 1, 8);
    #2;
    rst = 1'b1;
    #1;
    chk32("async reset", 32'h0, 32'h0, 2'b00, 6'd0);
    step();
    chk("reset held count", 64'(bus.busy_count), 64'd0);
    chk("reset held data0", 64'(bus.read_data[31:0]), 64'd0);
    rst = 1'b0;
    drive(2'b11, 5, 8, 0, 0, 32'h0, 0, 0);
    step();
    chk32("post reset", 32'h0, 32'h0, 2'b00, 6'd0);

    // Small configuration: fill every reservable register.
    for (int r = 1; r < 8; r++) begin
      bus8.reserve_enable = 1'b1;
      bus8.reserve_index  = 3'(r);
      step();
      chk($sformatf("dut8 reserve x%0d count", r), 64'(bus8.busy_count), 64'(r));
    end
    bus8.reserve_index = 3'd0;
    bus8.read_enable   = 3'b111;
    bus8.read_index    = {3'd7, 3'd4, 3'd1};
    step();
    chk("dut8 full count", 64'(bus8.busy_count), 64'd7);
    chk("dut8 busy all", 64'(bus8.read_busy), 64'b111);
    chk("dut8 data", 64'(bus8.read_data), 64'd0);
    bus8.reserve_enable = 1'b0;
    bus8.write_enable   = 1'b1;
    bus8.write_index    = 3'd4;
    bus8.write_data     = 16'hBEEF;
    step();
    chk("dut8 write count", 64'(bus8.busy_count), 64'd6);
    chk("dut8 bypass data1", 64'(bus8.read_data[31:16]), 64'hBEEF);
    chk("dut8 bypass busy", 64'(bus8.read_busy), 64'b101);
    bus8.write_enable = 1'b0;
    bus8.read_enable  = 3'b000;
    step();
    chk("dut8 hold data1", 64'(bus8.read_data[31:16]), 64'hBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
